// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the code lock.
// State encoding, clog2 and code digit selection.
package code_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_e;

  localparam int MAX_CODE_W = 256;

  // Ceil log2, never below 1 so counters keep a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Digit idx of a len-digit code; digit 0 is the MS digit.
  // Caller truncates the result to its digit width.
  function automatic logic [MAX_CODE_W-1:0] get_digit(
    input logic [MAX_CODE_W-1:0] code,
    input int                    idx,
    input int                    dw,
    input int                    len
  );
    return code >> ((len - 1 - idx) * dw);
  endfunction

endpackage

// File: rtl/press_detect.sv
// Registers a level button and emits a one-cycle press pulse.
// Ports: clk_i, rst_i (sync, high), btn_i level, press_o pulse.
module press_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic btn_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) btn_q <= 1'b0;
    else       btn_q <= btn_i;
  end

  assign press_o = btn_i & ~btn_q;

endmodule

// File: rtl/code_lock_fsm.sv
// Digit-sequence lock with retry budget, timed lockout, relock.
// Ports: clk, rst, btn, data_in, relock -> data_out, unlocked,
// locked_out, digit_idx, fail_cnt (all outputs registered).
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 3,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 12'h314,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 50_000_000,
  parameter int OUT_W       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             btn,
  input  logic [DIGIT_W-1:0]               data_in,
  input  logic                             relock,
  output logic [OUT_W-1:0]                 data_out,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic [clog2(CODE_LEN+1)-1:0]     digit_idx,
  output logic [clog2(MAX_TRIES+1)-1:0]    fail_cnt
);

  localparam int IW = clog2(CODE_LEN + 1);
  localparam int FW = clog2(MAX_TRIES + 1);
  localparam int TW = clog2(LOCK_CYCLES);

  state_e               state_q;
  logic [IW-1:0]        idx_q;
  logic [FW-1:0]        fail_q;
  logic [TW-1:0]        timer_q;
  logic                 mism_q;
  logic [OUT_W-1:0]     dout_q;
  logic                 unl_q;
  logic                 lo_q;

  logic                 press;
  logic [DIGIT_W-1:0]   exp_digit;
  logic                 dig_ok;
  logic                 last_dig;
  logic                 entry_ok;
  logic                 at_max;

  press_detect u_press (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn),
    .press_o (press)
  );

  assign exp_digit = DIGIT_W'(get_digit(MAX_CODE_W'(CODE),
                       int'(idx_q), DIGIT_W, CODE_LEN));
  assign dig_ok   = (data_in == exp_digit);
  assign last_dig = (idx_q == IW'(CODE_LEN - 1));
  assign entry_ok = ~mism_q & dig_ok;
  assign at_max   = (fail_q == FW'(MAX_TRIES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      idx_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      mism_q  <= 1'b0;
      dout_q  <= '0;
      unl_q   <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ENTRY: begin
          if (press) begin
            if (last_dig) begin
              // Full entry judged; wrong digit position not revealed.
              idx_q  <= '0;
              mism_q <= 1'b0;
              if (entry_ok) begin
                state_q <= UNLOCKED;
                fail_q  <= '0;
                dout_q  <= '1;
                unl_q   <= 1'b1;
              end else if (at_max) begin
                state_q <= LOCKOUT;
                fail_q  <= fail_q + FW'(1);
                timer_q <= TW'(LOCK_CYCLES - 1);
                lo_q    <= 1'b1;
              end else begin
                fail_q <= fail_q + FW'(1);
              end
            end else begin
              idx_q  <= idx_q + IW'(1);
              mism_q <= mism_q | ~dig_ok;
            end
          end
        end
        UNLOCKED: begin
          if (relock) begin
            state_q <= ENTRY;
            idx_q   <= '0;
            dout_q  <= '0;
            unl_q   <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            state_q <= ENTRY;
            fail_q  <= '0;
            lo_q    <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= ENTRY;
          idx_q   <= '0;
          mism_q  <= 1'b0;
          dout_q  <= '0;
          unl_q   <= 1'b0;
          lo_q    <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = dout_q;
  assign unlocked   = unl_q;
  assign locked_out = lo_q;
  assign digit_idx  = idx_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed scoreboard bench for code_lock_fsm.
// Two instances: 3x4-bit code 314 and 4x8-bit code DEADBEEF.
module tb_code_lock_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, btn_a = 1'b0, relock_a = 1'b0;
  logic [3:0] data_a = '0;
  logic [7:0] dout_a;
  logic       unl_a, lo_a;
  logic [1:0] idx_a, fail_a;

  logic       rst_b = 1'b1, btn_b = 1'b0, relock_b = 1'b0;
  logic [7:0] data_b = '0;
  logic [7:0] dout_b;
  logic       unl_b, lo_b;
  logic [2:0] idx_b;
  logic [1:0] fail_b;

  code_lock_fsm #(
    .DIGIT_W(4), .CODE_LEN(3), .CODE(12'h314),
    .MAX_TRIES(3), .LOCK_CYCLES(8), .OUT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst_a), .btn(btn_a), .data_in(data_a),
    .relock(relock_a), .data_out(dout_a), .unlocked(unl_a),
    .locked_out(lo_a), .digit_idx(idx_a), .fail_cnt(fail_a)
  );

  code_lock_fsm #(
    .DIGIT_W(8), .CODE_LEN(4), .CODE(32'hDEADBEEF),
    .MAX_TRIES(3), .LOCK_CYCLES(8), .OUT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst_b), .btn(btn_b), .data_in(data_b),
    .relock(relock_b), .data_out(dout_b), .unlocked(unl_b),
    .locked_out(lo_b), .digit_idx(idx_b), .fail_cnt(fail_b)
  );

  logic [14:0] obs_a, obs_b;
  assign obs_a = {dout_a, unl_a, lo_a, 1'b0, idx_a, fail_a};
  assign obs_b = {dout_b, unl_b, lo_b, idx_b, fail_b};

  typedef struct {
    string       tag;
    bit          b;
    logic [14:0] v;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit b,
                      input logic [7:0] d, input bit u, input bit l,
                      input int idx, input int f);
    exp_t e;
    e.tag = tag;
    e.b   = b;
    e.v   = {d, u, l, 3'(idx), 2'(f)};
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, 32'(e.b ? obs_b : obs_a), 32'(e.v));
    end
  endtask

  task automatic hit(input bit b, input logic [7:0] d);
    if (b) begin
      data_b = d;
      btn_b  = 1'b1;
    end else begin
      data_a = d[3:0];
      btn_a  = 1'b1;
    end
    tick();
  endtask

  task automatic rel();
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick();
  endtask

  task automatic press(input bit b, input logic [7:0] d);
    hit(b, d);
    rel();
  endtask

  logic [3:0] seqa [3] = '{4'h3, 4'h1, 4'h4};

  initial begin
    int cnt;
    int k;

    tick();
    tick();
    push("a_reset", 0, 8'h00, 0, 0, 0, 0);
    push("b_reset", 1, 8'h00, 0, 0, 0, 0);
    chk();
    chk();
    rst_a = 1'b0;
    rst_b = 1'b0;

    data_a = 4'h3;
    btn_a  = 1'b1;
    repeat (10) tick();
    btn_a = 1'b0;
    tick();
    push("held_one_press", 0, 8'h00, 0, 0, 1, 0);
    chk();
    press(0, 8'h1);
    hit(0, 8'h4);
    push("unlock_314", 0, 8'hFF, 1, 0, 0, 0);
    chk();
    rel();

    relock_a = 1'b1;
    hit(0, 8'h3);
    relock_a = 1'b0;
    push("relock_with_press", 0, 8'h00, 0, 0, 0, 0);
    chk();
    rel();

    press(0, 8'h3);
    press(0, 8'h2);
    push("wrong_idx2", 0, 8'h00, 0, 0, 2, 0);
    chk();
    press(0, 8'h4);
    push("wrong_324", 0, 8'h00, 0, 0, 0, 1);
    chk();

    press(0, 8'h0);
    press(0, 8'h0);
    press(0, 8'h0);
    push("wrong_second", 0, 8'h00, 0, 0, 0, 2);
    chk();
    press(0, 8'h0);
    press(0, 8'h0);
    hit(0, 8'h0);
    push("lockout_enter", 0, 8'h00, 0, 1, 0, 3);
    chk();

    cnt = 1;
    k   = 0;
    for (int i = 0; i < 100 && lo_a; i++) begin
      if (btn_a) begin
        btn_a = 1'b0;
      end else begin
        data_a = seqa[k % 3];
        k++;
        btn_a = 1'b1;
      end
      tick();
      if (lo_a) cnt++;
    end
    cmp("lockout_len", 32'(cnt), 32'd8);
    push("lockout_exit", 0, 8'h00, 0, 0, 0, 0);
    chk();
    rel();

    press(0, 8'h3);
    press(0, 8'h1);
    press(0, 8'h4);
    push("unlock_after_lockout", 0, 8'hFF, 1, 0, 0, 0);
    chk();
    relock_a = 1'b1;
    tick();
    relock_a = 1'b0;
    push("relock_pulse", 0, 8'h00, 0, 0, 0, 0);
    chk();

    press(0, 8'h3);
    press(0, 8'h1);
    push("mid_entry_idx2", 0, 8'h00, 0, 0, 2, 0);
    chk();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    push("mid_entry_reset", 0, 8'h00, 0, 0, 0, 0);
    chk();
    press(0, 8'h3);
    press(0, 8'h1);
    press(0, 8'h4);
    push("unlock_after_reset", 0, 8'hFF, 1, 0, 0, 0);
    chk();

    press(1, 8'hDE);
    press(1, 8'hAD);
    push("b_idx2", 1, 8'h00, 0, 0, 2, 0);
    chk();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    push("b_mid_reset", 1, 8'h00, 0, 0, 0, 0);
    chk();
    press(1, 8'hDE);
    press(1, 8'hAD);
    press(1, 8'hBE);
    press(1, 8'hEE);
    push("b_wrong_last", 1, 8'h00, 0, 0, 0, 1);
    chk();
    press(1, 8'hDE);
    press(1, 8'hAD);
    press(1, 8'hBE);
    hit(1, 8'hEF);
    push("b_unlock", 1, 8'hFF, 1, 0, 0, 0);
    chk();
    rel();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
